dmem_arbiter: RTL

Two-port arbiter and sequencer for the single-port data memory behind the single-cycle CPU. It shares the memory between the CPU data port and a debug/loader port. Each winning request is issued to memory as a registered single-cycle command, the block waits out the memory read latency, and then returns data with a one-cycle ack. The CPU holds its PC while `cpu_stall` is high. The debug port uses the same req/ack protocol.

---
 rtl/dmem_arb_pkg.sv | 36 +++
 rtl/dmem_arbiter_rr_arb2.sv | 45 ++++
 rtl/dmem_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Sequencer states: command issue, read-latency wait, completion pulse.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Requesting port identities.
  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DBG = 1'b1
  } port_t;

  // Supported memory read latency range and the counter width that covers it.
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int LAT_CNT_W   = 3;

  // Keep the latency inside the range the counter and FSM are built for.
  function automatic int clamp_lat(input int lat);
    int res;
    if (lat < MEM_LAT_MIN) begin
      res = MEM_LAT_MIN;
    end else if (lat > MEM_LAT_MAX) begin
      res = MEM_LAT_MAX;
    end else begin
      res = lat;
    end
    return res;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker; remembers which port won last.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  port_t      last_grant_r;
  logic [1:0] pick_s;

  // Choose a winner: single requester wins, a tie goes to the port not granted last.
  always_comb begin
    pick_s = 2'b00;
    case (req)
      2'b01:   pick_s = 2'b01;
      2'b10:   pick_s = 2'b10;
      2'b11: begin
        if (last_grant_r == PORT_DBG) begin
          pick_s = 2'b01;
        end else begin
          pick_s = 2'b10;
        end
      end
      default: pick_s = 2'b00;
    endcase
  end

  assign grant = en ? pick_s : 2'b00;

  // Record the port that received each grant; DBG after reset so the CPU goes first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_r <= PORT_DBG;
    end else if (grant != 2'b00) begin
      last_grant_r <= grant[1] ? PORT_DBG : PORT_CPU;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU and a debug/loader port.
// Each grant becomes a registered one-cycle memory command, the read latency is
// waited out, and the owner receives a one-cycle ack.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int                   LAT      = clamp_lat(MEM_LAT);
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT);
  localparam logic [LAT_CNT_W-1:0] CNT_ONE  = LAT_CNT_W'(1);

  state_t               state_r;
  state_t               state_s;
  port_t                owner_r;
  logic [LAT_CNT_W-1:0] cnt_r;
  logic [DW-1:0]        rd_q;
  logic [1:0]           grant_s;
  logic                 grant_en_s;
  logic                 capture_s;

  assign grant_en_s = (state_r == IDLE);
  assign capture_s  = (state_r == WAIT) && (cnt_r <= CNT_ONE);

  rr_arb2 u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   ({dbg_req, cpu_req}),
    .en    (grant_en_s),
    .grant (grant_s)
  );

  // Next-state logic of the access sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s != 2'b00) begin
          state_s = ACCESS;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (mem_we) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r <= CNT_ONE) begin
          state_s = DONE;
        end else begin
          state_s = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the winner's command in IDLE; it stays frozen for the whole transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r   <= PORT_CPU;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_s[1]) begin
      owner_r   <= PORT_DBG;
      mem_we    <= dbg_we;
      mem_addr  <= dbg_addr;
      mem_wdata <= dbg_wdata;
    end else if (grant_s[0]) begin
      owner_r   <= PORT_CPU;
      mem_we    <= cpu_we;
      mem_addr  <= cpu_addr;
      mem_wdata <= cpu_wdata;
    end else begin
      owner_r   <= owner_r;
      mem_we    <= mem_we;
      mem_addr  <= mem_addr;
      mem_wdata <= mem_wdata;
    end
  end

  // Registered strobes: memory enable, owner acks and busy follow the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_en  <= 1'b0;
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      busy    <= 1'b0;
    end else begin
      mem_en  <= (state_s == ACCESS);
      cpu_ack <= (state_s == DONE) && (owner_r == PORT_CPU);
      dbg_ack <= (state_s == DONE) && (owner_r == PORT_DBG);
      busy    <= (state_s != IDLE);
    end
  end

  // Read-latency counter: loaded while the command is issued, counts down in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == ACCESS) begin
      cnt_r <= LAT_LOAD;
    end else if ((state_r == WAIT) && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Shared read-data register; only a read capture changes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q <= '0;
    end else if (capture_s) begin
      rd_q <= mem_rdata;
    end else begin
      rd_q <= rd_q;
    end
  end

  assign cpu_rdata = rd_q;
  assign dbg_rdata = rd_q;
  assign cpu_stall = cpu_req & ~cpu_ack;

endmodule
